// File: rtl/rfx_axil_reg_responder.sv
// AXI4-Lite register responder: four RW control words, a sampled status
// word and a 16-bit accepted-write counter behind independent R/W FSMs.
module rfx_axil_reg_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic [3:0]                        wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_VALID} rstate_t;

    wstate_t             wstate;
    rstate_t             rstate;
    logic [3:0][DW-1:0]  regs;
    logic [15:0]         wr_count;
    logic [2:0]          aw_word_q;
    logic [DW-1:0]       wdata_q;
    logic [SW-1:0]       wstrb_q;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                commit;
    logic [2:0]          c_word;
    logic [DW-1:0]       c_data;
    logic [SW-1:0]       c_strb;
    logic [2:0]          ar_word;
    logic [DW-1:0]       rd_data;
    logic [1:0]          rd_resp;
    logic                unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs    = S_AXI_AWREADY & S_AXI_AWVALID;
    assign w_hs     = S_AXI_WREADY & S_AXI_WVALID;
    assign ar_hs    = S_AXI_ARREADY & S_AXI_ARVALID;
    assign ar_word  = S_AXI_ARADDR[4:2];
    assign ctrl_out = regs;

    // Pick the address/data pair that completes the write on this edge
    always_comb begin
        commit = 1'b0;
        c_word = aw_word_q;
        c_data = wdata_q;
        c_strb = wstrb_q;
        unique case (wstate)
            W_IDLE: begin
                commit = aw_hs & w_hs;
                c_word = S_AXI_AWADDR[4:2];
                c_data = S_AXI_WDATA;
                c_strb = S_AXI_WSTRB;
            end
            W_HAVE_AW: begin
                commit = w_hs;
                c_data = S_AXI_WDATA;
                c_strb = S_AXI_WSTRB;
            end
            W_HAVE_W: begin
                commit = aw_hs;
                c_word = S_AXI_AWADDR[4:2];
            end
            default: commit = 1'b0;
        endcase
    end

    // Write channel FSM with registered ready/valid/response
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            aw_word_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else if (commit) begin
            wstate        <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= c_word[2] ? 2'b10 : 2'b00;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_word_q     <= S_AXI_AWADDR[4:2];
                        wstate        <= W_HAVE_AW;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                    end else if (w_hs) begin
                        wdata_q       <= S_AXI_WDATA;
                        wstrb_q       <= S_AXI_WSTRB;
                        wstate        <= W_HAVE_W;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b0;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wstate        <= W_IDLE;
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register bank, write strobes and accepted-write counter
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs     <= '0;
            wr_pulse <= '0;
            wr_count <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && !c_word[2] && (c_strb != '0)) begin
                for (int i = 0; i < SW; i++) begin
                    if (c_strb[i])
                        regs[c_word[1:0]][8*i +: 8] <= c_data[8*i +: 8];
                end
                wr_pulse[c_word[1:0]] <= 1'b1;
                wr_count              <= wr_count + 16'd1;
            end
        end
    end

    // Read data mux, evaluated against pre-write register contents
    always_comb begin
        rd_data = '0;
        rd_resp = 2'b00;
        unique case (ar_word)
            3'd4:       rd_data = status_in;
            3'd5:       rd_data = {{(DW-16){1'b0}}, wr_count};
            3'd6, 3'd7: rd_resp = 2'b10;
            default:    rd_data = regs[ar_word[1:0]];
        endcase
    end

    // Read channel FSM with registered ready/valid/payload
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate        <= R_VALID;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_data;
                        S_AXI_RRESP   <= rd_resp;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        rstate        <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rfx_axil_reg_responder.sv
// Bench for rfx_axil_reg_responder: directed scenarios plus randomized
// traffic checked against a register-map model of the block.
module tb_rfx_axil_reg_responder;

    logic          tb_ACLK = 1'b0;
    logic          ARESET;
    logic [4:0]    S_AXI_AWADDR;
    logic [2:0]    S_AXI_AWPROT;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [4:0]    S_AXI_ARADDR;
    logic [2:0]    S_AXI_ARPROT;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [127:0]  ctrl_out;
    logic [3:0]    wr_pulse;
    logic [31:0]   status_in;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [31:0]   m_reg [4];
    int            m_cnt;

    always #5 tb_ACLK = ~tb_ACLK;

    rfx_axil_reg_responder dut (
        .ACLK          (tb_ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_out      (ctrl_out),
        .wr_pulse      (wr_pulse),
        .status_in     (status_in)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] m_ctrl();
        return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_cnt = 0;
    endtask

    // Expected read payload for a word, from the register-map rules
    task automatic exp_read(input logic [2:0] wd, output logic [31:0] d,
                            output logic [1:0] r);
        r = 2'b00;
        d = '0;
        if (wd < 3'd4)       d = m_reg[wd[1:0]];
        else if (wd == 3'd4) d = status_in;
        else if (wd == 3'd5) d = {16'h0, m_cnt[15:0]};
        else                 r = 2'b10;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly);
        bit         aw_done = 0;
        bit         w_done = 0;
        int         cyc = 0;
        logic [2:0] wd = addr[4:2];
        logic [1:0] er;
        logic [3:0] ep;
        er = wd[2] ? 2'b10 : 2'b00;
        ep = (!wd[2] && strb != 4'h0) ? (4'b0001 << wd[1:0]) : 4'b0000;
        while (!(aw_done && w_done)) begin
            @(negedge tb_ACLK);
            if (cyc > 60) begin
                check("wr_handshake", 128'({aw_done, w_done}), 128'(3));
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
                return;
            end
            S_AXI_AWADDR  = addr;
            S_AXI_WDATA   = data;
            S_AXI_WSTRB   = strb;
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_done = 1;
            cyc++;
        end
        @(posedge tb_ACLK);
        if (ep != 4'h0) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) m_reg[wd[1:0]][8*i +: 8] = data[8*i +: 8];
            m_cnt = (m_cnt + 1) % 65536;
        end
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("bvalid", 128'(S_AXI_BVALID), 128'(1));
        check("bresp", 128'(S_AXI_BRESP), 128'(er));
        check("wr_pulse", 128'(wr_pulse), 128'(ep));
        check("ctrl_out", ctrl_out, m_ctrl());
        for (int i = 0; i < b_dly; i++) begin
            @(negedge tb_ACLK);
            check("b_hold", 128'({S_AXI_BVALID, S_AXI_BRESP,
                                  S_AXI_AWREADY, S_AXI_WREADY}),
                  128'({1'b1, er, 1'b0, 1'b0}));
        end
        S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        S_AXI_BREADY = 1'b0;
        check("b_done", 128'({S_AXI_BVALID, wr_pulse}), 128'(0));
    endtask

    task automatic axi_read(input logic [4:0] addr, input int ar_dly,
                            input int r_dly);
        bit          done = 0;
        int          cyc = 0;
        logic [31:0] ed = '0;
        logic [1:0]  er = '0;
        while (!done) begin
            @(negedge tb_ACLK);
            if (cyc > 60) begin
                check("ar_handshake", 128'(done), 128'(1));
                S_AXI_ARVALID = 1'b0;
                return;
            end
            S_AXI_ARADDR  = addr;
            S_AXI_ARVALID = cyc >= ar_dly;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                done = 1;
                exp_read(addr[4:2], ed, er);
            end
            cyc++;
        end
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid", 128'(S_AXI_RVALID), 128'(1));
        check("rdata", 128'(S_AXI_RDATA), 128'(ed));
        check("rresp", 128'(S_AXI_RRESP), 128'(er));
        for (int i = 0; i < r_dly; i++) begin
            status_in = $urandom;
            @(negedge tb_ACLK);
            check("r_hold", 128'({S_AXI_RVALID, S_AXI_ARREADY,
                                  S_AXI_RRESP, S_AXI_RDATA}),
                  128'({1'b1, 1'b0, er, ed}));
        end
        S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        S_AXI_RREADY = 1'b0;
        check("r_done", 128'(S_AXI_RVALID), 128'(0));
    endtask

    initial begin
        logic seen_b;
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        status_in     = 32'hC0FFEE01;
        model_clear();
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        check("reset_hs", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                S_AXI_ARREADY, S_AXI_RVALID}), 128'(0));
        check("reset_pay", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}),
              128'(0));
        check("reset_ctrl", ctrl_out, 128'(0));
        check("reset_pulse", 128'(wr_pulse), 128'(0));
        ARESET = 1'b0;

        axi_write(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0);
        axi_write(5'h04, 32'hABCD0001, 4'hF, 0, 0, 0);
        axi_write(5'h08, 32'hDEAD0011, 4'hF, 0, 0, 0);
        axi_write(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0);
        for (int i = 0; i < 6; i++) axi_read(5'(4 * i), 0, 0);

        axi_write(5'h04, 32'h12345678, 4'h3, 3, 0, 0);
        axi_read(5'h04, 0, 0);
        check("reg1_merge", ctrl_out[63:32], 128'(32'hABCD5678));

        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_read(5'h10, 0, 0);
        axi_read(5'h14, 0, 0);
        axi_read(5'h18, 0, 0);
        axi_write(5'h00, 32'h00000000, 4'h0, 0, 0, 0);
        axi_read(5'h00, 0, 0);

        axi_write(5'h0C, 32'h0BADF00D, 4'hF, 0, 0, 10);
        axi_write(5'h0C, 32'h600DCAFE, 4'hF, 0, 1, 0);

        check("pre_collide", 128'(m_reg[2]), 128'(32'hDEAD0011));
        fork
            axi_write(5'h08, 32'h55AA55AA, 4'hF, 0, 0, 0);
            axi_read(5'h08, 0, 0);
        join
        axi_read(5'h08, 0, 0);

        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 2);
            logic [4:0]  a = 5'($urandom);
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom);
            if (op == 0) begin
                axi_write(a, d, s, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op == 1) begin
                status_in = $urandom;
                axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                logic [4:0] ra = 5'($urandom);
                status_in = $urandom;
                fork
                    axi_write(a, d, s, $urandom_range(0, 2),
                              $urandom_range(0, 2), $urandom_range(0, 2));
                    axi_read(ra, $urandom_range(0, 2), $urandom_range(0, 2));
                join
            end
        end

        @(negedge tb_ACLK);
        S_AXI_AWADDR  = 5'h00;
        S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR  = 5'h00;
        S_AXI_ARVALID = 1'b1;
        check("pre_rst_rdy", 128'({S_AXI_AWREADY, S_AXI_ARREADY}), 128'(3));
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("pre_rst_rv", 128'({S_AXI_RVALID, S_AXI_WREADY,
                                  S_AXI_AWREADY}), 128'(6));
        ARESET = 1'b1;
        @(negedge tb_ACLK);
        check("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID, wr_pulse}),
              128'(0));
        check("rst_ctrl", ctrl_out, 128'(0));
        ARESET = 1'b0;
        model_clear();
        seen_b = 1'b0;
        repeat (6) begin
            @(negedge tb_ACLK);
            seen_b = seen_b | S_AXI_BVALID;
        end
        check("rst_no_b", 128'(seen_b), 128'(0));
        axi_read(5'h14, 0, 0);
        axi_read(5'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
